// File: rtl/lfsr8_checker_pkg.sv
// Shared LFSR definitions: FSM state encoding, feedback tap mask and the
// next-state function used by both the upstream generator and the checker.
package lfsr8_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  // Feedback taps at bits 7, 6, 3 and 0; the register shifts right.
  localparam logic [7:0] TAP_MASK = 8'b1100_1001;

  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {^(s & TAP_MASK), s[7:1]};
  endfunction

endpackage

// File: rtl/lfsr8_checker_if.sv
// Sample/status bundle between an LFSR source (master) and the checker (slave).
// Handshake: din is consumed on any posedge clk where valid is high; there is no back-pressure.
interface lfsr8_checker_if #(
  parameter int ERR_W = 16
);
  import lfsr8_pkg::*;

  logic             valid;
  logic [7:0]       din;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic             stuck_zero;
  state_t           state_dbg;

  modport master (
    output valid, din, clr_cnt,
    input  locked, err_pulse, err_cnt, stuck_zero, state_dbg
  );

  modport slave (
    input  valid, din, clr_cnt,
    output locked, err_pulse, err_cnt, stuck_zero, state_dbg
  );

endinterface

// File: rtl/lfsr8_checker_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module lfsr8_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr8_checker.sv
// Tracks an 8-bit LFSR stream: hunts for a seed, acquires lock, counts mismatches.
// Optional feature: define LFSR8_CHK_ZERO_DET_EN to reject the all-zero lockup state.
module lfsr8_checker
  import lfsr8_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  lfsr8_checker_if.slave  bus
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  state_t     state_q;
  logic [7:0] exp_q;
  logic [3:0] match_q;
  logic [3:0] miss_q;
  logic       locked_q;
  logic       err_pulse_q;

  logic       zero_hit;
  logic       lock_miss;

`ifdef LFSR8_CHK_ZERO_DET_EN
  logic stuck_q;

  assign zero_hit = bus.valid && (bus.din == 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck_q <= 1'b0;
    end else if (zero_hit) begin
      stuck_q <= 1'b1;
    end
  end

  assign bus.stuck_zero = stuck_q;
`else
  assign zero_hit       = 1'b0;
  assign bus.stuck_zero = 1'b0;
`endif

  // While locked, a zero sample is always treated as an error when zero detection is on.
  assign lock_miss = bus.valid && (state_q == LOCK) && ((bus.din != exp_q) || zero_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      exp_q       <= 8'h00;
      match_q     <= 4'd0;
      miss_q      <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bus.valid) begin
        unique case (state_q)
          HUNT: begin
            if (!zero_hit) begin
              exp_q   <= nxt(bus.din);
              match_q <= 4'd0;
              state_q <= ACQ;
            end
          end
          ACQ: begin
            if (zero_hit) begin
              match_q <= 4'd0;
              state_q <= HUNT;
            end else if (bus.din == exp_q) begin
              exp_q <= nxt(bus.din);
              if (match_q + 4'd1 == LOCK_N) begin
                match_q  <= 4'd0;
                miss_q   <= 4'd0;
                locked_q <= 1'b1;
                state_q  <= LOCK;
              end else begin
                match_q <= match_q + 4'd1;
              end
            end else begin
              exp_q   <= nxt(bus.din);
              match_q <= 4'd0;
            end
          end
          LOCK: begin
            if (lock_miss) begin
              // Free-run the prediction so a single corrupt word does not derail tracking.
              err_pulse_q <= 1'b1;
              exp_q       <= nxt(exp_q);
              if (miss_q + 4'd1 == LOSS_N) begin
                miss_q   <= 4'd0;
                match_q  <= 4'd0;
                locked_q <= 1'b0;
                state_q  <= HUNT;
              end else begin
                miss_q <= miss_q + 4'd1;
              end
            end else begin
              miss_q <= 4'd0;
              exp_q  <= nxt(bus.din);
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  lfsr8_sat_cnt #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (lock_miss),
    .clr_i (bus.clr_cnt),
    .cnt_o (bus.err_cnt)
  );

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_lfsr8_checker.sv
// Directed bench for lfsr8_checker: lock, error counting, loss of lock, saturation,
// gapped valid, asynchronous reset and all-zero handling.
module tb_lfsr8_checker;
  import lfsr8_pkg::*;

  localparam int ERR_W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lfsr8_checker_if #(.ERR_W(ERR_W)) bus ();

  lfsr8_checker #(
    .LOCK_CNT (4),
    .LOSS_CNT (3),
    .ERR_W    (ERR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] gen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_nxt(input logic [7:0] s);
    return {s[7] ^ s[6] ^ s[3] ^ s[0], s[7:1]};
  endfunction

  function automatic logic [7:0] bad_of(input logic [7:0] e);
    logic [7:0] b;
    b = e ^ 8'h01;
    if (b == 8'h00) b = 8'h02;
    return b;
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.din   = d;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
  endtask

  task automatic send_good();
    send(gen);
    gen = ref_nxt(gen);
  endtask

  task automatic send_bad();
    send(bad_of(gen));
    gen = ref_nxt(gen);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.valid   = 1'b0;
    bus.din     = 8'h00;
    bus.clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_locked", 32'(bus.locked), 32'd0);
    check_eq("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
    check_eq("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    check_eq("rst_stuck", 32'(bus.stuck_zero), 32'd0);
    check_eq("rst_state", 32'(bus.state_dbg), 32'(HUNT));
    @(negedge clk);
    rst = 1'b0;

    // Hand-derived sequence A5 -> 52 -> A9 -> D4 -> 6A -> 35 -> 9A -> 4D.
    send(8'hA5);
    check_eq("seed_state", 32'(bus.state_dbg), 32'(ACQ));
    send(8'h52);
    send(8'hA9);
    send(8'hD4);
    check_eq("pre_lock", 32'(bus.locked), 32'd0);
    send(8'h6A);
    check_eq("lock", 32'(bus.locked), 32'd1);
    check_eq("lock_err_cnt", 32'(bus.err_cnt), 32'd0);
    check_eq("lock_state", 32'(bus.state_dbg), 32'(LOCK));

    // Expected 35, send a corrupted word instead.
    send(8'hCA);
    check_eq("miss_pulse", 32'(bus.err_pulse), 32'd1);
    check_eq("miss_cnt", 32'(bus.err_cnt), 32'd1);
    check_eq("miss_locked", 32'(bus.locked), 32'd1);
    idle(1);
    check_eq("pulse_one_cycle", 32'(bus.err_pulse), 32'd0);
    check_eq("idle_cnt_hold", 32'(bus.err_cnt), 32'd1);
    send(8'h9A);
    gen = 8'h4D;
    check_eq("good_no_pulse", 32'(bus.err_pulse), 32'd0);
    send_bad();
    send_bad();
    send_good();
    check_eq("miss_cleared", 32'(bus.locked), 32'd1);
    check_eq("miss_cnt3", 32'(bus.err_cnt), 32'd3);

    // Three consecutive misses drop lock.
    send_bad();
    send_bad();
    check_eq("two_miss_locked", 32'(bus.locked), 32'd1);
    send_bad();
    check_eq("loss_locked", 32'(bus.locked), 32'd0);
    check_eq("loss_cnt", 32'(bus.err_cnt), 32'd6);
    check_eq("loss_state", 32'(bus.state_dbg), 32'(HUNT));
    repeat (4) send_good();
    check_eq("relock_pre", 32'(bus.locked), 32'd0);
    send_good();
    check_eq("relock", 32'(bus.locked), 32'd1);

    // Saturation with isolated mismatches, then clear coincident with a miss.
    do_reset();
    #1;
    check_eq("sat_rst_cnt", 32'(bus.err_cnt), 32'd0);
    gen = 8'hA5;
    repeat (5) send_good();
    for (int i = 0; i < 20; i++) begin
      send_bad();
      if (i == 14) check_eq("sat_reach", 32'(bus.err_cnt), 32'd15);
      send_good();
    end
    check_eq("sat_hold", 32'(bus.err_cnt), 32'd15);
    check_eq("sat_locked", 32'(bus.locked), 32'd1);
    @(negedge clk);
    bus.valid   = 1'b1;
    bus.din     = bad_of(gen);
    bus.clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    bus.valid   = 1'b0;
    bus.clr_cnt = 1'b0;
    gen = ref_nxt(gen);
    check_eq("clr_wins", 32'(bus.err_cnt), 32'd0);
    check_eq("clr_pulse", 32'(bus.err_pulse), 32'd1);
    send_good();
    send_bad();
    check_eq("post_clr_cnt", 32'(bus.err_cnt), 32'd1);

    // Valid gapped 1-in-3: lock still lands on the fifth valid sample.
    do_reset();
    gen = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      send_good();
      idle(2);
      check_eq("gap_locked", 32'(bus.locked), (i == 4) ? 32'd1 : 32'd0);
      check_eq("gap_pulse", 32'(bus.err_pulse), 32'd0);
    end

    // Asynchronous reset mid-ACQ and mid-LOCK with a live error pulse.
    do_reset();
    gen = 8'hA5;
    send_good();
    send_good();
    check_eq("acq_state", 32'(bus.state_dbg), 32'(ACQ));
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_acq_state", 32'(bus.state_dbg), 32'(HUNT));
    check_eq("arst_acq_locked", 32'(bus.locked), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    gen = 8'hA5;
    repeat (5) send_good();
    send_bad();
    check_eq("pre_arst_pulse", 32'(bus.err_pulse), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_pulse", 32'(bus.err_pulse), 32'd0);
    check_eq("arst_cnt", 32'(bus.err_cnt), 32'd0);
    check_eq("arst_locked", 32'(bus.locked), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First sample after reset is a seed, on a sequence phase not seen before.
    gen = 8'h35;
    repeat (4) send_good();
    check_eq("reseed_pre", 32'(bus.locked), 32'd0);
    send_good();
    check_eq("reseed_lock", 32'(bus.locked), 32'd1);

    // All-zero input.
    do_reset();
    repeat (4) send(8'h00);
    check_eq("zero_pre", 32'(bus.locked), 32'd0);
    send(8'h00);
`ifdef LFSR8_CHK_ZERO_DET_EN
    check_eq("zero_locked", 32'(bus.locked), 32'd0);
    check_eq("zero_stuck", 32'(bus.stuck_zero), 32'd1);
    check_eq("zero_state", 32'(bus.state_dbg), 32'(HUNT));
`else
    check_eq("zero_locked", 32'(bus.locked), 32'd1);
    check_eq("zero_stuck", 32'(bus.stuck_zero), 32'd0);
    check_eq("zero_state", 32'(bus.state_dbg), 32'(LOCK));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
